instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning max in-flight imem requests plus buffered instructions.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_rsp_valid  input  1  in-order response valid, no backpressure.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port stall_Ps2  input  1  decode cannot accept this cycle.
REQ-013 SHALL have port InstructionPs2  output  32 (t_instruction)  instruction to decode.
REQ-014 SHALL have port PcPs2  output  32 (t_xlen)  PC of InstructionPs2.
REQ-015 SHALL have port ValidPs2  output  1  InstructionPs2 is real, not a bubble.
REQ-016 SHALL have ports perf_fetch_cnt, perf_bubble_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-017 SHALL hold fetch PC register; request handshake completes when imem_req_valid && imem_req_ready, then PC <= PC+4, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-018 SHALL assert imem_req_valid only in RUN and only when in-flight + buffered < MAX_OUTSTANDING; imem_req_addr stable while valid && !ready.
REQ-019 SHALL push each non-discarded response into a MAX_OUTSTANDING-entry FIFO together with its request PC; minimum request-to-output latency 2 cycles.
REQ-020 SHALL present FIFO head on InstructionPs2/PcPs2 with ValidPs2=1; pop when ValidPs2 && !stall_Ps2.
REQ-021 SHALL drive InstructionPs2 = NOP (32'h0000_0013), ValidPs2=0 when FIFO empty; outputs hold unchanged while stall_Ps2=1.
REQ-022 SHALL support simultaneous push and pop on a full FIFO without loss.
REQ-023 SHALL implement FSM BOOT -> RUN (one cycle after rst deasserts), RUN -> DRAIN on redirect_valid with in-flight>0, RUN -> RUN on redirect_valid with in-flight=0, DRAIN -> RUN when in-flight reaches 0.
REQ-024 SHALL on redirect_valid: flush FIFO, ValidPs2=0 next cycle, PC <= {redirect_pc[31:2],2'b00}; redirect wins over a same-cycle request handshake and pop.
REQ-025 SHALL in DRAIN discard every response and issue no requests; redirect in DRAIN updates PC, stays in DRAIN.

Reset
REQ-026 SHALL on rst: PC=RESET_PC, FSM=BOOT, FIFO empty, in-flight=0, imem_req_valid=0, ValidPs2=0, InstructionPs2=NOP, PcPs2=0, perf counters=0.
REQ-027 SHALL on rst mid-transaction discard all outstanding responses arriving after rst deasserts only if memory is also reset; memory is reset with instr_fetch.

Configuration
REQ-028 SHALL, with IFETCH_PERF_CNT_EN defined, count perf_fetch_cnt per pop and perf_bubble_cnt per cycle with ValidPs2=0 && FSM!=BOOT, saturating at 32'hFFFF_FFFF.
REQ-029 SHALL, without IFETCH_PERF_CNT_EN, keep ports present and tie both counters to 0 with no counter flops.

Structure
REQ-030 SHALL take t_xlen, t_instruction, the NOP constant and RESET_PC default from the shared core package.
REQ-031 SHALL place the instruction/PC buffer in sub-module ifetch_fifo.

Verification
REQ-032 SHALL cover reset then ready=1, 1-cycle response: addresses 0,4,8 issued; ValidPs2 first high 2 cycles after first handshake, PcPs2 0,4,8.
REQ-033 SHALL cover stall_Ps2=1 for 5 cycles with FIFO full: imem_req_valid=0, InstructionPs2 held, no lost or duplicated instruction.
REQ-034 SHALL cover redirect_valid, redirect_pc=32'h0000_0103 with 2 in flight: DRAIN, both responses dropped, next request addr 32'h0000_0100.
REQ-035 SHALL cover PC 32'hFFFF_FFFC fetched: next request addr 32'h0000_0000.
REQ-036 SHALL cover rst asserted mid-burst: all outputs at reset values same cycle, first request to RESET_PC after BOOT.
REQ-037 SHALL cover IFETCH_PERF_CNT_EN build, 10 pops and 3 bubbles: counters read 10 and 3; other build reads 0 and 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared core types, NOP constant and fetch FSM states
package instr_fetch_pkg;

  typedef logic [31:0] t_xlen;
  typedef logic [31:0] t_instruction;

  localparam t_instruction NOP              = 32'h0000_0013;
  localparam t_xlen        RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } t_fetch_state;

  function automatic t_xlen align_pc(input t_xlen pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - instruction/PC buffer between fetch responses and decode
module ifetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  t_instruction  push_instr,
  input  t_xlen         push_pc,
  input  logic          pop,
  output logic          head_valid,
  output t_instruction  head_instr,
  output t_xlen         head_pc,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  t_instruction  instr_mem [DEPTH];
  t_xlen         pc_mem    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - credit-limited instruction fetch with redirect drain
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter t_xlen RESET_PC        = RESET_PC_DEFAULT,
  parameter int    MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_valid,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         stall_Ps2,
  output t_instruction InstructionPs2,
  output t_xlen        PcPs2,
  output logic         ValidPs2,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_bubble_cnt
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  t_fetch_state  state;
  t_fetch_state  next_state;
  t_xlen         pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] buffered;
  logic          room;
  logic          req_fire;
  logic          rsp_push;
  logic          pop;
  logic          fifo_valid;
  t_instruction  head_instr;
  t_xlen         head_pc;
  t_xlen         rsp_pc;

  assign room = (32'(inflight) + 32'(buffered)) < 32'(MAX_OUTSTANDING);

  always_comb begin
    next_state     = state;
    imem_req_valid = 1'b0;
    case (state)
      BOOT:  next_state = RUN;
      RUN: begin
        imem_req_valid = room && !redirect_valid;
        if (redirect_valid && (inflight != '0)) next_state = DRAIN;
      end
      DRAIN: if (!redirect_valid && (inflight == '0)) next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_push = imem_rsp_valid && (state == RUN) && !redirect_valid;
  assign pop      = fifo_valid && !stall_Ps2 && !redirect_valid;

  // In RUN the outstanding requests are consecutive words ending just below pc.
  assign rsp_pc = pc - (32'(inflight) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      inflight <= '0;
    end else begin
      state <= next_state;
      if (redirect_valid)  pc <= align_pc(redirect_pc);
      else if (req_fire)   pc <= pc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid && (inflight != '0));
    end
  end

  assign imem_req_addr = pc;

  ifetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (rsp_push),
    .push_instr (imem_rsp_data),
    .push_pc    (rsp_pc),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (buffered)
  );

  assign ValidPs2       = fifo_valid;
  assign InstructionPs2 = fifo_valid ? head_instr : NOP;
  assign PcPs2          = fifo_valid ? head_pc : '0;

`ifdef IFETCH_PERF_CNT_EN
  t_xlen fetch_cnt;
  t_xlen bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (pop && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if (!fifo_valid && (state != BOOT) && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt;
  assign perf_bubble_cnt = bubble_cnt;
`else
  assign perf_fetch_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch with a latency-configurable memory model
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int MAXO = 2;
`ifdef IFETCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req_valid;
  logic [31:0]  imem_req_addr;
  logic         imem_req_ready = 1'b0;
  logic         imem_rsp_valid = 1'b0;
  logic [31:0]  imem_rsp_data = 32'h0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         stall_Ps2 = 1'b0;
  t_instruction InstructionPs2;
  t_xlen        PcPs2;
  logic         ValidPs2;
  logic [31:0]  perf_fetch_cnt;
  logic [31:0]  perf_bubble_cnt;

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall_Ps2       (stall_Ps2),
    .InstructionPs2  (InstructionPs2),
    .PcPs2           (PcPs2),
    .ValidPs2        (ValidPs2),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { t_xlen addr; int due; bit drop; } mem_ent_t;
  typedef struct { t_xlen pc; t_instruction instr; } exp_ent_t;

  mem_ent_t memq[$];
  exp_ent_t expq[$];

  int    ntests = 0;
  int    nfail = 0;
  int    cyc = 0;
  int    lat = 1;
  int    npops = 0;
  int    nbub = 0;
  int    nhs = 0;
  int    first_hs = -1;
  int    first_valid = -1;
  bit    drain = 0;
  bit    saw_wrap = 0;
  t_xlen exp_addr = 32'h0;
  t_xlen last_hs_obs = 32'hDEAD_BEEF;
  t_instruction held;

  logic  nx_ready = 1'b1;
  logic  nx_stall = 1'b0;
  logic  nx_redir = 1'b0;
  t_xlen nx_redir_pc = 32'h0;

  function automatic t_instruction mem_data(input t_xlen a);
    return {a[31:2], 2'b00} ^ 32'h5A3C_0F11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall_Ps2 = 1'b0;
    nx_ready = 1'b1; nx_stall = 1'b0; nx_redir = 1'b0; nx_redir_pc = 32'h0;
    #1;
    chk("rst_req_valid", imem_req_valid, 32'h0);
    chk("rst_valid_ps2", ValidPs2, 32'h0);
    chk("rst_instr_nop", InstructionPs2, NOP);
    chk("rst_pc_ps2", PcPs2, 32'h0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_bubble", perf_bubble_cnt, 32'h0);
    memq.delete(); expq.delete();
    exp_addr = 32'h0; npops = 0; nbub = 0; nhs = 0; cyc = 0;
    first_hs = -1; first_valid = -1; drain = 0; last_hs_obs = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_req_valid", imem_req_valid, 32'h0);
  endtask

  task automatic step();
    mem_ent_t m;
    bit rsp_now;
    bit hs;
    int infl;
    int nbuf;
    @(negedge clk);
    imem_req_ready = nx_ready;
    stall_Ps2      = nx_stall;
    redirect_valid = nx_redir;
    redirect_pc    = nx_redir_pc;
    rsp_now = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_data(memq[0].addr) : 32'h0;
    #1;
    infl = memq.size();
    nbuf = expq.size();
    chk("valid_ps2", ValidPs2, (nbuf != 0) ? 32'd1 : 32'd0);
    if (nbuf != 0) begin
      chk("instr_ps2", InstructionPs2, expq[0].instr);
      chk("pc_ps2", PcPs2, expq[0].pc);
    end else begin
      chk("instr_nop", InstructionPs2, NOP);
    end
    chk("req_valid", imem_req_valid, (!drain && !nx_redir && (infl + nbuf < MAXO)) ? 32'd1 : 32'd0);
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_addr);
    chk("perf_fetch", perf_fetch_cnt, PERF_ON ? npops : 0);
    chk("perf_bubble", perf_bubble_cnt, PERF_ON ? nbub : 0);

    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      if (first_hs < 0) first_hs = cyc;
      if (last_hs_obs == 32'hFFFF_FFFC && imem_req_addr == 32'h0) saw_wrap = 1;
      last_hs_obs = imem_req_addr;
      nhs++;
      memq.push_back('{exp_addr, cyc + lat, 1'b0});
      exp_addr += 32'd4;
    end
    if (nbuf == 0) nbub++;
    else if (first_valid < 0) first_valid = cyc;
    if (nbuf != 0 && !nx_stall && !nx_redir) begin
      npops++;
      void'(expq.pop_front());
    end
    if (rsp_now) begin
      m = memq.pop_front();
      if (!m.drop && !nx_redir) expq.push_back('{m.addr, mem_data(m.addr)});
    end
    if (nx_redir) begin
      foreach (memq[i]) memq[i].drop = 1;
      expq.delete();
      if (infl > 0) drain = 1;
      exp_addr = {nx_redir_pc[31:2], 2'b00};
    end else if (drain && infl == 0) begin
      drain = 0;
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int b;
    do_reset();

    // Back-to-back fetch, 1-cycle memory: 0,4,8 and first ValidPs2 two cycles after first handshake.
    lat = 1;
    repeat (8) step();
    chk("first_hs_cycle", first_hs, 32'd0);
    chk("first_valid_latency", first_valid - first_hs, 32'd2);

    // Decode stalls with a full buffer: no requests, head held.
    nx_stall = 1'b1;
    for (int i = 0; i < 10 && expq.size() < MAXO; i++) step();
    chk("fill_bound", expq.size(), MAXO);
    held = expq[0].instr;
    repeat (5) begin
      step();
      chk("stall_req_valid", imem_req_valid, 32'h0);
      chk("stall_instr_held", InstructionPs2, held);
    end
    nx_stall = 1'b0;
    repeat (8) step();

    // Redirect to an unaligned target with two requests in flight.
    lat = 3;
    for (int i = 0; i < 20 && memq.size() < 2; i++) step();
    chk("two_inflight_bound", memq.size(), 32'd2);
    nx_redir = 1'b1; nx_redir_pc = 32'h0000_0103;
    step();
    nx_redir = 1'b0;
    chk("drain_after_redirect", drain, 32'd1);
    hs0 = nhs;
    for (int i = 0; i < 20 && nhs == hs0; i++) step();
    chk("redirect_next_addr", last_hs_obs, 32'h0000_0100);
    repeat (10) step();

    // Fetch across the top of the address space.
    lat = 1;
    nx_redir = 1'b1; nx_redir_pc = 32'hFFFF_FFFC;
    step();
    nx_redir = 1'b0;
    repeat (15) step();
    chk("pc_wrap", saw_wrap, 32'd1);

    // Reset in the middle of a burst, then restart at RESET_PC.
    repeat (3) step();
    do_reset();
    step();
    chk("restart_addr", last_hs_obs, RESET_PC_DEFAULT);

    // Counter run: ten pops from a fresh reset with occasional stalls.
    do_reset();
    for (int i = 0; i < 80 && npops < 10; i++) begin
      nx_stall = (i % 7 == 5);
      step();
    end
    nx_stall = 1'b1;
    b = nbub;
    step();
    chk("perf_fetch_10", perf_fetch_cnt, PERF_ON ? 32'd10 : 32'd0);
    chk("perf_bubble_run", perf_bubble_cnt, PERF_ON ? b : 0);
    nx_stall = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
